// File: rtl/usb_bulk_pkg.sv
// Constants shared by the USB bulk datapath (ulpi_bulk_axis and axis_bulk_framer).
package usb_bulk_pkg;

    localparam int HS_MAX_PACKET         = 512;
    localparam int FS_MAX_PACKET         = 64;
    localparam int DEFAULT_FLUSH_TIMEOUT = 1024;

    // Framer occupancy, derived from (hv, hd, O valid).
    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StReady,
        StDrain
    } framer_state_e;

endpackage

// File: rtl/axis_bulk_framer.sv
// Bulk IN framer: cuts an unframed AXI4-Stream into packets of at most MAX_PACKET bytes.
// Build option AXIS_BULK_FRAMER_TIMEOUT_EN adds a hold stage that flushes idle partial packets.
module axis_bulk_framer
    import usb_bulk_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_PACKET = HS_MAX_PACKET,
    parameter int TIMEOUT    = DEFAULT_FLUSH_TIMEOUT,
    parameter int CBITS      = $clog2(MAX_PACKET + 1),
    parameter int TBITS      = $clog2(TIMEOUT)
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  s_axis_tvalid_i,
    output logic                  s_axis_tready_o,
    input  logic                  s_axis_tlast_i,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_i,
    output logic                  m_axis_tvalid_o,
    input  logic                  m_axis_tready_i,
    output logic                  m_axis_tlast_o,
    output logic [DATA_WIDTH-1:0] m_axis_tdata_o
);

    logic                  r_o_valid;
    logic                  r_o_last;
    logic [DATA_WIDTH-1:0] r_o_data;
    logic [CBITS-1:0]      r_cnt;
    logic                  w_o_free;
    logic                  w_accept;
    logic [CBITS-1:0]      w_cnt_next;
    logic                  w_new_last;

    assign w_o_free        = !r_o_valid || m_axis_tready_i;
    assign m_axis_tvalid_o = r_o_valid;
    assign m_axis_tlast_o  = r_o_last;
    assign m_axis_tdata_o  = r_o_data;

`ifdef AXIS_BULK_FRAMER_TIMEOUT_EN
    logic                  r_hv;
    logic                  r_hd;
    logic                  r_hl;
    logic [DATA_WIDTH-1:0] r_h_data;
    logic [TBITS-1:0]      r_timer;
    framer_state_e         w_state;
    logic                  w_expired;
    logic                  w_xfer;
    logic                  w_h_last;
    logic                  w_clear;
    logic [CBITS-1:0]      w_cnt_base;

    always_comb begin
        if (!r_hv) begin
            w_state = r_o_valid ? StDrain : StIdle;
        end else begin
            w_state = r_hd ? StReady : StHold;
        end
    end

    // An undecided byte leaves H only alongside a new arrival, so H frees exactly when O does.
    assign s_axis_tready_o = (w_state == StIdle) || (w_state == StDrain) || w_o_free;
    assign w_accept        = s_axis_tvalid_i && s_axis_tready_o;
    assign w_expired       = (r_timer == TBITS'(TIMEOUT - 1));
    assign w_xfer          = w_o_free && ((w_state == StReady) ||
                             ((w_state == StHold) && (s_axis_tvalid_i || w_expired)));
    // A following byte outranks the flush: the held byte then goes out as a middle byte.
    assign w_h_last        = r_hd ? r_hl : !s_axis_tvalid_i;
    assign w_clear         = w_xfer && w_h_last;
    assign w_cnt_base      = w_clear ? '0 : r_cnt;
    assign w_cnt_next      = w_cnt_base + CBITS'(1);
    assign w_new_last      = s_axis_tlast_i || (w_cnt_next == CBITS'(MAX_PACKET));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_hv      <= 1'b0;
            r_hd      <= 1'b0;
            r_hl      <= 1'b0;
            r_h_data  <= '0;
            r_timer   <= '0;
            r_cnt     <= '0;
            r_o_valid <= 1'b0;
            r_o_last  <= 1'b0;
            r_o_data  <= '0;
        end else begin
            if (w_accept) begin
                r_h_data <= s_axis_tdata_i;
                r_hv     <= 1'b1;
                r_hd     <= w_new_last;
                r_hl     <= w_new_last;
                r_timer  <= '0;
                r_cnt    <= w_cnt_next;
            end else begin
                if (w_xfer) begin
                    r_hv    <= 1'b0;
                    r_hd    <= 1'b0;
                    r_hl    <= 1'b0;
                    r_timer <= '0;
                end else if ((w_state == StHold) && !w_expired) begin
                    r_timer <= r_timer + TBITS'(1);
                end
                if (w_clear) begin
                    r_cnt <= '0;
                end
            end
            if (w_xfer) begin
                r_o_valid <= 1'b1;
                r_o_data  <= r_h_data;
                r_o_last  <= w_h_last;
            end else if (m_axis_tready_i) begin
                r_o_valid <= 1'b0;
            end
        end
    end
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT > TBITS);
    assign s_axis_tready_o  = w_o_free;
    assign w_accept         = s_axis_tvalid_i && s_axis_tready_o;
    assign w_cnt_next       = r_cnt + CBITS'(1);
    assign w_new_last       = s_axis_tlast_i || (w_cnt_next == CBITS'(MAX_PACKET));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cnt     <= '0;
            r_o_valid <= 1'b0;
            r_o_last  <= 1'b0;
            r_o_data  <= '0;
        end else begin
            if (w_accept) begin
                r_o_valid <= 1'b1;
                r_o_data  <= s_axis_tdata_i;
                r_o_last  <= w_new_last;
                r_cnt     <= w_new_last ? '0 : w_cnt_next;
            end else if (m_axis_tready_i) begin
                r_o_valid <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_bulk_framer.sv
// Self-checking bench for axis_bulk_framer; follows AXIS_BULK_FRAMER_TIMEOUT_EN if defined.
module tb_axis_bulk_framer;
    import usb_bulk_pkg::*;

    localparam int DW   = 8;
    localparam int MAXP = HS_MAX_PACKET;
    localparam int TMO  = 20;
`ifdef AXIS_BULK_FRAMER_TIMEOUT_EN
    localparam int LAT_LAST     = 2;
    localparam int FLUSH_TLASTS = 2;
    localparam bit GAP_LAST     = 1'b1;
`else
    localparam int LAT_LAST     = 1;
    localparam int FLUSH_TLASTS = 1;
    localparam bit GAP_LAST     = 1'b0;
`endif

    logic          aclk     = 1'b0;
    logic          aresetn  = 1'b0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          s_tlast  = 1'b0;
    logic [DW-1:0] s_tdata  = '0;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          m_tlast;
    logic [DW-1:0] m_tdata;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit bp_mode  = 1'b0;
    int low_run  = 0;
    bit stall_seen = 1'b0;
    logic [DW-1:0] stall_data;
    logic          stall_last;

    logic [DW-1:0] in_data[$];
    bit            in_last[$];
    int            in_t[$];
    logic [DW-1:0] out_data[$];
    bit            out_last[$];
    int            out_t[$];
    logic [DW-1:0] exp_data[$];
    bit            exp_last[$];

    axis_bulk_framer #(
        .DATA_WIDTH(DW),
        .MAX_PACKET(MAXP),
        .TIMEOUT   (TMO)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s_axis_tvalid_i(s_tvalid),
        .s_axis_tready_o(s_tready),
        .s_axis_tlast_i (s_tlast),
        .s_axis_tdata_i (s_tdata),
        .m_axis_tvalid_o(m_tvalid),
        .m_axis_tready_i(m_tready),
        .m_axis_tlast_o (m_tlast),
        .m_axis_tdata_o (m_tdata)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    // Bounded random backpressure: never low for more than 6 cycles in a row.
    always @(posedge aclk) begin
        #1;
        if (bp_mode) begin
            m_tready = (low_run >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
            low_run  = m_tready ? 0 : low_run + 1;
        end
    end

    // Handshakes are sampled mid-cycle and stamped with the edge that completes them.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (s_tvalid && s_tready) begin
                in_data.push_back(s_tdata);
                in_last.push_back(s_tlast);
                in_t.push_back(cyc + 1);
            end
            if (m_tvalid && m_tready) begin
                out_data.push_back(m_tdata);
                out_last.push_back(m_tlast);
                out_t.push_back(cyc + 1);
            end
            if (stall_seen) begin
                checks++;
                if (m_tvalid !== 1'b1 || m_tdata !== stall_data || m_tlast !== stall_last) begin
                    failures++;
                    $display("FAIL o_stable got=%b/%h/%b want=1/%h/%b", m_tvalid, m_tdata, m_tlast,
                             stall_data, stall_last);
                end
            end
            stall_seen = m_tvalid && !m_tready;
            stall_data = m_tdata;
            stall_last = m_tlast;
        end else begin
            stall_seen = 1'b0;
        end
    end

    task automatic clear_q();
        in_data.delete();  in_last.delete();  in_t.delete();
        out_data.delete(); out_last.delete(); out_t.delete();
    endtask

    task automatic do_reset();
        bp_mode  = 1'b0;
        m_tready = 1'b1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        @(posedge aclk);
        #2 aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk) aresetn = 1'b1;
        @(posedge aclk);
        #1;
        clear_q();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the byte.
    task automatic push(input logic [DW-1:0] d, input bit l);
        int w = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        @(negedge aclk);
        while (!s_tready && w < 100) begin
            w++;
            @(negedge aclk);
        end
        if (w >= 100) begin
            checks++;
            failures++;
            $display("FAIL push_wait got=stalled want=accepted within 100 cycles");
        end
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    // Packet rules: a byte closes its packet on upstream tlast or on the MAX_PACKET-th byte;
    // with the flush timer, also when no further byte is accepted within TMO edges.
    task automatic build_model();
        int n;
        bit last;
        n = 0;
        exp_data.delete();
        exp_last.delete();
        foreach (in_data[i]) begin
            n++;
            last = in_last[i] || (n == MAXP);
`ifdef AXIS_BULK_FRAMER_TIMEOUT_EN
            if (i == in_data.size() - 1 || in_t[i+1] - in_t[i] > TMO) last = 1'b1;
`endif
            if (last) n = 0;
            exp_data.push_back(in_data[i]);
            exp_last.push_back(last);
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        #3;
        checks += 4;
        if (m_tvalid !== 1'b0) begin failures++; $display("FAIL rst_tvalid got=%b want=0", m_tvalid); end
        if (m_tlast !== 1'b0) begin failures++; $display("FAIL rst_tlast got=%b want=0", m_tlast); end
        if (m_tdata !== '0) begin failures++; $display("FAIL rst_tdata got=%h want=00", m_tdata); end
        if (s_tready !== 1'b1) begin failures++; $display("FAIL rst_tready got=%b want=1", s_tready); end
    endtask

    task automatic test_timeout_flush();
        int nl = 0;
        do_reset();
        for (int i = 0; i < 1000; i++) push(DW'($urandom), 1'b0);
        idle(TMO + 10);
        build_model();
        checks++;
        if (out_data.size() != 1000) begin
            failures++;
            $display("FAIL flush_len got=%0d want=1000", out_data.size());
        end
        for (int i = 0; i < out_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if (out_data[i] !== exp_data[i] || out_last[i] !== exp_last[i]) begin
                failures++;
                $display("FAIL flush_byte%0d got=%h/%0b want=%h/%0b", i, out_data[i], out_last[i],
                         exp_data[i], exp_last[i]);
            end
        end
        foreach (out_last[i]) nl += int'(out_last[i]);
        checks++;
        if (nl != FLUSH_TLASTS) begin
            failures++;
            $display("FAIL flush_tlasts got=%0d want=%0d", nl, FLUSH_TLASTS);
        end
        if (out_last.size() >= MAXP) begin
            checks++;
            if (out_last[MAXP-1] !== 1'b1) begin
                failures++;
                $display("FAIL flush_first_pkt got=%0b want=1", out_last[MAXP-1]);
            end
        end
`ifdef AXIS_BULK_FRAMER_TIMEOUT_EN
        checks++;
        if (out_t.size() == 0 || in_t.size() == 0 || out_t[$] - in_t[$] != TMO + 1) begin
            failures++;
            $display("FAIL flush_latency got=%0d want=%0d",
                     (out_t.size() > 0 && in_t.size() > 0) ? out_t[$] - in_t[$] : -1, TMO + 1);
        end
`endif
    endtask

    task automatic test_short_tlast();
        int nl = 0;
        do_reset();
        for (int i = 0; i < 3; i++) push(DW'($urandom), i == 2);
        idle(TMO + 10);
        build_model();
        checks++;
        if (out_data.size() != 3) begin
            failures++;
            $display("FAIL short_len got=%0d want=3", out_data.size());
        end
        for (int i = 0; i < out_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if (out_data[i] !== exp_data[i] || out_last[i] !== exp_last[i]) begin
                failures++;
                $display("FAIL short_byte%0d got=%h/%0b want=%h/%0b", i, out_data[i], out_last[i],
                         exp_data[i], exp_last[i]);
            end
        end
        foreach (out_last[i]) nl += int'(out_last[i]);
        checks++;
        if (nl != 1) begin failures++; $display("FAIL short_tlasts got=%0d want=1", nl); end
        checks++;
        if (out_t.size() != 3 || in_t.size() != 3 || out_t[2] - in_t[2] != LAT_LAST) begin
            failures++;
            $display("FAIL short_latency got=%0d want=%0d",
                     (out_t.size() == 3 && in_t.size() == 3) ? out_t[2] - in_t[2] : -1, LAT_LAST);
        end
    endtask

    task automatic test_tlast_at_max();
        int nl = 0;
        do_reset();
        for (int i = 0; i < MAXP; i++) push(DW'($urandom), i == MAXP - 1);
        idle(TMO + 10);
        build_model();
        checks++;
        if (out_data.size() != MAXP) begin
            failures++;
            $display("FAIL max_len got=%0d want=%0d", out_data.size(), MAXP);
        end
        for (int i = 0; i < out_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if (out_data[i] !== exp_data[i] || out_last[i] !== exp_last[i]) begin
                failures++;
                $display("FAIL max_byte%0d got=%h/%0b want=%h/%0b", i, out_data[i], out_last[i],
                         exp_data[i], exp_last[i]);
            end
        end
        foreach (out_last[i]) nl += int'(out_last[i]);
        checks++;
        if (nl != 1) begin failures++; $display("FAIL max_tlasts got=%0d want=1", nl); end
    endtask

    task automatic test_backpressure();
        int nl = 0;
        do_reset();
        bp_mode = 1'b1;
        for (int i = 0; i < 4 * MAXP; i++) push(DW'($urandom), 1'b0);
        bp_mode = 1'b0;
        m_tready = 1'b1;
        idle(TMO + 10);
        build_model();
        checks++;
        if (out_data.size() != 4 * MAXP) begin
            failures++;
            $display("FAIL bp_len got=%0d want=%0d", out_data.size(), 4 * MAXP);
        end
        for (int i = 0; i < out_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if (out_data[i] !== exp_data[i] || out_last[i] !== exp_last[i]) begin
                failures++;
                $display("FAIL bp_byte%0d got=%h/%0b want=%h/%0b", i, out_data[i], out_last[i],
                         exp_data[i], exp_last[i]);
            end
        end
        foreach (out_last[i]) nl += int'(out_last[i]);
        checks++;
        if (nl != 4) begin failures++; $display("FAIL bp_tlasts got=%0d want=4", nl); end
    endtask

    task automatic test_accept_at_expiry();
        int gaps[7];
        gaps[0] = TMO;
        gaps[1] = TMO + 1;
        for (int i = 2; i < 7; i++) gaps[i] = $urandom_range(TMO - 2, TMO + 2);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            push(DW'($urandom), 1'b0);
            if (i < 7 && gaps[i] > 1) begin
                repeat (gaps[i] - 1) @(posedge aclk);
                #1;
            end
        end
        idle(TMO + 10);
        build_model();
        checks++;
        if (in_t.size() < 2 || in_t[1] - in_t[0] != TMO) begin
            failures++;
            $display("FAIL expiry_gap got=%0d want=%0d",
                     (in_t.size() >= 2) ? in_t[1] - in_t[0] : -1, TMO);
        end
        checks++;
        if (out_data.size() != 8) begin
            failures++;
            $display("FAIL expiry_len got=%0d want=8", out_data.size());
        end
        if (out_last.size() >= 2) begin
            checks += 2;
            if (out_last[0] !== 1'b0) begin
                failures++;
                $display("FAIL expiry_accept_wins got=%0b want=0", out_last[0]);
            end
            if (out_last[1] !== GAP_LAST) begin
                failures++;
                $display("FAIL expiry_flush got=%0b want=%0b", out_last[1], GAP_LAST);
            end
        end
        for (int i = 0; i < out_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if (out_data[i] !== exp_data[i] || out_last[i] !== exp_last[i]) begin
                failures++;
                $display("FAIL expiry_byte%0d got=%h/%0b want=%h/%0b", i, out_data[i],
                         out_last[i], exp_data[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int nl = 0;
        do_reset();
        for (int i = 0; i < 100; i++) push(DW'($urandom), 1'b0);
        #2 aresetn = 1'b0;
        #1;
        checks += 4;
        if (m_tvalid !== 1'b0) begin failures++; $display("FAIL mrst_tvalid got=%b want=0", m_tvalid); end
        if (m_tlast !== 1'b0) begin failures++; $display("FAIL mrst_tlast got=%b want=0", m_tlast); end
        if (m_tdata !== '0) begin failures++; $display("FAIL mrst_tdata got=%h want=00", m_tdata); end
        if (s_tready !== 1'b1) begin failures++; $display("FAIL mrst_tready got=%b want=1", s_tready); end
        repeat (2) @(posedge aclk);
        @(negedge aclk) aresetn = 1'b1;
        @(posedge aclk);
        #1;
        clear_q();
        for (int i = 0; i < MAXP; i++) push(DW'($urandom), 1'b0);
        idle(TMO + 10);
        build_model();
        checks++;
        if (out_data.size() != MAXP) begin
            failures++;
            $display("FAIL mrst_len got=%0d want=%0d", out_data.size(), MAXP);
        end
        for (int i = 0; i < out_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if (out_data[i] !== exp_data[i] || out_last[i] !== exp_last[i]) begin
                failures++;
                $display("FAIL mrst_byte%0d got=%h/%0b want=%h/%0b", i, out_data[i], out_last[i],
                         exp_data[i], exp_last[i]);
            end
        end
        foreach (out_last[i]) nl += int'(out_last[i]);
        checks++;
        if (nl != 1 || out_last.size() != MAXP || out_last[MAXP-1] !== 1'b1) begin
            failures++;
            $display("FAIL mrst_pkt got=%0d tlasts want=1 at byte %0d", nl, MAXP);
        end
    endtask

    initial begin
        test_reset();
        test_timeout_flush();
        test_short_tlast();
        test_tlast_at_max();
        test_backpressure();
        test_accept_at_expiry();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
